cart_load_arbiter: RTL and testbench



---
 rtl/coco3_mem_pkg.sv | 26 ++
 rtl/load_fifo.sv | 64 ++++++
 rtl/cart_load_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cart_load_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coco3_mem_pkg.sv
// Shared types for the cartridge loader and memory-port arbiter.
// No logic of its own; no latency.
// No flow control; types only.
package coco3_mem_pkg;

  // Address width the FIFO entry is built for; the arbiter's ADDR_W must match it.
  localparam int MEM_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } load_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CPU  = 2'd1,
    G_LOAD = 2'd2
  } grant_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } fifo_entry_t;

endpackage

// File: rtl/load_fifo.sv
// Generic synchronous first-word-fall-through FIFO used to buffer loader bytes.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push while full is ignored, pop while empty is ignored; caller watches full/empty.
module load_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; DEPTH is a power of 2 so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset flushes the FIFO without touching storage.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cart_load_arbiter.sv
// Streams cartridge bytes from the ioctl download into system RAM, sharing the port with the CPU.
// Latency: uncontended CPU or loader access appears on the registered memory port 1 cycle after grant.
// Backpressure: none toward ioctl (full FIFO drops the byte and flags overflow); CPU waits on cpu_ack.
module cart_load_arbiter
  import coco3_mem_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hA000,
  parameter logic [7:0]      LOAD_INDEX = 8'd1,
  parameter int              FIFO_DEPTH = 4,
  parameter int              STARVE_MAX = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_overflow,
  output logic [15:0]       bytes_written
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  load_state_t         state_q, state_d;
  grant_t              grant;
  fifo_entry_t         push_ent, head_ent;
  logic                push_req, fifo_empty, fifo_full, load_start;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         bytes_q, bytes_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d, cpu_ack_q, cpu_ack_d;
  logic                load_wr_q, load_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_din_q, mem_din_d;
  logic                addr_hi_unused;

  // Image offsets wrap within the memory window; upper offset bits are deliberately dropped.
  assign addr_hi_unused = ^ioctl_addr[24:ADDR_W];
  assign push_ent.addr  = BASE_ADDR + ioctl_addr[ADDR_W-1:0];
  assign push_ent.data  = ioctl_data;
  assign push_req       = (state_q == LOAD) && ioctl_wr && (ioctl_index == LOAD_INDEX);

  load_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 8)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push_req),
    .pop     (grant == G_LOAD),
    .din     (push_ent),
    .dout    (head_ent),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Load sequencing: IDLE -> LOAD on a matching download, LOAD -> DRAIN when it ends,
  // DRAIN -> IDLE once the buffer and the last loader write have both cleared.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (ioctl_download && (ioctl_index == LOAD_INDEX)) begin
          state_d    = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD:    if (!ioctl_download) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !load_wr_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port arbitration: CPU first unless the loader has starved for STARVE_MAX cycles.
  // A CPU request is skipped the cycle its ack is showing, so one held request gets one ack.
  always_comb begin
    grant = G_NONE;
    if (!fifo_empty && (!cpu_req || (starve_q == STARVE_W'(STARVE_MAX)))) grant = G_LOAD;
    else if (cpu_req && !cpu_ack_q)                                        grant = G_CPU;
  end

  // Registered memory-port drive, starvation counter and load statistics.
  always_comb begin
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_din_d  = '0;
    cpu_ack_d  = 1'b0;
    load_wr_d  = 1'b0;
    starve_d   = starve_q;
    ovf_d      = ovf_q;
    bytes_d    = bytes_q;
    case (grant)
      G_CPU: begin
        mem_en_d   = 1'b1;
        mem_we_d   = cpu_we;
        mem_addr_d = cpu_addr;
        mem_din_d  = cpu_din;
        cpu_ack_d  = 1'b1;
      end
      G_LOAD: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = head_ent.addr;
        mem_din_d  = head_ent.data;
        load_wr_d  = 1'b1;
      end
      default: ;
    endcase
    if (fifo_empty || (grant == G_LOAD))         starve_d = '0;
    else if (starve_q != STARVE_W'(STARVE_MAX))  starve_d = starve_q + STARVE_W'(1);
    if (load_start) begin
      ovf_d   = 1'b0;
      bytes_d = '0;
    end else begin
      if (push_req && fifo_full)                   ovf_d   = 1'b1;
      if ((grant == G_LOAD) && (bytes_q != 16'hFFFF)) bytes_d = bytes_q + 16'd1;
    end
  end

  // State and output registers; reset clears everything mid-load as well.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      ovf_q      <= 1'b0;
      bytes_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cpu_ack_q  <= 1'b0;
      load_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ovf_q      <= ovf_d;
      bytes_q    <= bytes_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_ack_q  <= cpu_ack_d;
      load_wr_q  <= load_wr_d;
    end
  end

  assign cpu_ack       = cpu_ack_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_din       = mem_din_q;
  assign load_busy     = (state_q != IDLE);
  assign cpu_hold      = load_busy;
  assign load_overflow = ovf_q;
  assign bytes_written = bytes_q;

endmodule

// File: tb/tb_cart_load_arbiter.sv
// Bench for cart_load_arbiter: loader writes are scoreboarded and matched as they reach the memory port.
// Latency: expected cycles are derived from the push cycle and the starvation limit.
// Backpressure: CPU requests are held high in the contention sequences.
module tb_cart_load_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_data;
  logic [24:0] ioctl_addr;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ack, mem_en, mem_we, cpu_hold, load_busy, load_overflow;
  logic [15:0] mem_addr, bytes_written;
  logic [7:0]  mem_din;

  always #5 clk_sys = ~clk_sys;

  cart_load_arbiter dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_din        (cpu_din),
    .cpu_ack        (cpu_ack),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .cpu_hold       (cpu_hold),
    .load_busy      (load_busy),
    .load_overflow  (load_overflow),
    .bytes_written  (bytes_written)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;   // -1 when the exact cycle is not checked
  } exp_t;

  typedef struct {
    logic [24:0] ioctl_addr;
    logic [7:0]  data;
    logic [15:0] exp_addr;
  } vec_t;

  exp_t  sb_q[$];
  int    load_cyc_q[$];
  bit    ack_hist[int];
  vec_t  vecs[5];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    load_cnt = 0;
  logic  prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (load_busy && n < max) begin
      step(1);
      n++;
    end
    check("idle_timeout", load_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"},   mem_en, 0);
    check({tag, "_cpu_ack"},  cpu_ack, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_busy"},     load_busy, 0);
    check({tag, "_hold"},     cpu_hold, 0);
    check({tag, "_ovf"},      load_overflow, 0);
    check({tag, "_bytes"},    bytes_written, 0);
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Port monitor: every CPU ack and every loader write is checked as it appears.
  always @(negedge clk_sys) begin
    ack_hist[cyc] = cpu_ack;
    if (cpu_ack === 1'b1) begin
      check("ack_mem_en", mem_en, 1);
      check("ack_single_pulse", prev_ack, 0);
      check("cpu_addr_pass", mem_addr, 16'h1234);
      check("cpu_din_pass", mem_din, 8'h5A);
      check("cpu_we_pass", mem_we, 1);
    end else if (mem_en === 1'b1) begin
      exp_t e;
      load_cnt++;
      load_cyc_q.push_back(cyc);
      check("ld_we", mem_we, 1);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ld_unexpected: loader write %h=%h at cycle %0d, required none", mem_addr, mem_din, cyc);
      end else begin
        e = sb_q.pop_front();
        check("ld_addr", mem_addr, e.addr);
        check("ld_data", mem_din, e.data);
        if (e.cyc >= 0) check("ld_cycle", cyc, e.cyc);
      end
    end
    prev_ack = cpu_ack;
  end

  initial begin
    int t0, base;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd1;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    cpu_req        = 1'b0;
    cpu_we         = 1'b1;
    cpu_addr       = 16'h1234;
    cpu_din        = 8'h5A;

    vecs[0] = '{25'h0000000, 8'h11, 16'hA000};
    vecs[1] = '{25'h0000001, 8'h22, 16'hA001};
    vecs[2] = '{25'h0000002, 8'h33, 16'hA002};
    vecs[3] = '{25'h0006000, 8'h44, 16'h0000};
    vecs[4] = '{25'h0010005, 8'h55, 16'hA005};

    step(3);
    check_all_zero("reset");
    reset = 1'b0;

    // Uncontended load: each byte lands one cycle after its push.
    ioctl_download = 1'b1;
    step(1);
    check("load_busy_on", load_busy, 1);
    check("cpu_hold_on", cpu_hold, 1);
    for (int i = 0; i < 5; i++) begin
      ioctl_addr = vecs[i].ioctl_addr;
      ioctl_data = vecs[i].data;
      ioctl_wr   = 1'b1;
      sb_q.push_back('{vecs[i].exp_addr, vecs[i].data, cyc + 2});
      step(1);
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    wait_idle(50);
    check("t1_bytes", bytes_written, 5);
    check("t1_ovf", load_overflow, 0);
    check("t1_sb_drained", sb_q.size(), 0);

    // Contended load: CPU holds its request, loader preempts after STARVE_MAX cycles.
    cpu_req        = 1'b1;
    ioctl_download = 1'b1;
    step(1);
    t0   = cyc;
    base = load_cyc_q.size();
    ioctl_addr = 25'h100; ioctl_data = 8'hA1; ioctl_wr = 1'b1;
    sb_q.push_back('{16'hA100, 8'hA1, t0 + 10});
    step(1);
    ioctl_addr = 25'h101; ioctl_data = 8'hA2;
    sb_q.push_back('{16'hA101, 8'hA2, t0 + 19});
    step(1);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    for (int n = 0; n < 60 && load_cyc_q.size() < base + 2; n++) step(1);
    step(2);
    check("t2_writes", load_cyc_q.size() - base, 2);
    if (load_cyc_q.size() >= base + 2) begin
      check("t2_cpu_after_ld1", ack_hist[load_cyc_q[base] + 1], 1);
      check("t2_cpu_after_ld2", ack_hist[load_cyc_q[base + 1] + 1], 1);
    end
    wait_idle(50);
    check("t2_bytes", bytes_written, 2);

    // Overflow: five back-to-back bytes into a 4-entry buffer while the CPU hogs the port.
    ioctl_download = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      ioctl_addr = 25'h200 + 25'(i);
      ioctl_data = 8'hB0 + 8'(i);
      ioctl_wr   = 1'b1;
      if (i < 4) sb_q.push_back('{16'hA200 + 16'(i), 8'hB0 + 8'(i), -1});
      step(1);
    end
    ioctl_wr = 1'b0;
    check("t3_ovf_set", load_overflow, 1);
    ioctl_download = 1'b0;
    wait_idle(200);
    check("t3_bytes", bytes_written, 4);
    check("t3_ovf_sticky", load_overflow, 1);
    ioctl_download = 1'b1;
    step(1);
    check("t3_ovf_cleared", load_overflow, 0);
    check("t3_bytes_cleared", bytes_written, 0);
    ioctl_download = 1'b0;
    wait_idle(20);

    // Foreign index: nothing is loaded and the CPU is never held.
    cpu_req        = 1'b0;
    ioctl_index    = 8'd2;
    ioctl_download = 1'b1;
    base           = load_cnt;
    step(1);
    check("t4_hold_off", cpu_hold, 0);
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(i);
      ioctl_data = 8'hC0 + 8'(i);
      ioctl_wr   = 1'b1;
      step(1);
    end
    ioctl_wr = 1'b0;
    check("t4_busy_off", load_busy, 0);
    ioctl_download = 1'b0;
    step(3);
    check("t4_no_writes", load_cnt - base, 0);
    check("t4_bytes", bytes_written, 0);
    ioctl_index = 8'd1;

    // Reset during DRAIN with three bytes still queued.
    cpu_req        = 1'b1;
    ioctl_download = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'h300 + 25'(i);
      ioctl_data = 8'hD0 + 8'(i);
      ioctl_wr   = 1'b1;
      step(1);
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    step(1);
    check("t5_in_drain", load_busy, 1);
    reset = 1'b1;
    step(1);
    check_all_zero("t5_reset");
    reset   = 1'b0;
    cpu_req = 1'b0;
    base    = load_cnt;
    step(30);
    check("t5_no_writes", load_cnt - base, 0);
    check("t5_idle", load_busy, 0);

    check("sb_final_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
